// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: load results take priority and ALU results wait in a FIFO.
// It also keeps per-register pending counters. Define WB_BYPASS_EN to forward the registered write to the query ports.
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int PCW   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aluValid,
    input  logic [4:0]  aluReg,
    input  logic [31:0] aluData,
    output logic        aluReady,
    input  logic        memValid,
    input  logic [4:0]  memReg,
    input  logic [31:0] memData,
    input  logic        issueValid,
    input  logic [4:0]  issueReg,
    output logic        issueReady,
    input  logic [4:0]  queryReg1,
    input  logic [4:0]  queryReg2,
    output logic        busy1,
    output logic        busy2,
    output logic        bypassValid1,
    output logic        bypassValid2,
    output logic [31:0] bypassData1,
    output logic [31:0] bypassData2,
    output logic        writeEnable,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]     r_fifo_reg  [DEPTH];
    logic [31:0]    r_fifo_data [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [PCW-1:0] r_pend [32];

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_mem_sel;
    logic        w_pop;
    logic        w_wr_fire;
    logic [4:0]  w_wr_reg;
    logic [31:0] w_wr_data;
    logic        w_inc;
    logic [31:0] w_inc_vec;
    logic [31:0] w_dec_vec;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign aluReady  = !w_full;
    assign w_push    = aluValid && !w_full && (aluReg != 5'd0);
    assign w_mem_sel = memValid && (memReg != 5'd0);
    assign w_pop     = !w_mem_sel && !w_empty;
    assign w_wr_fire = w_mem_sel || w_pop;
    assign w_wr_reg  = w_mem_sel ? memReg  : r_fifo_reg[r_rptr];
    assign w_wr_data = w_mem_sel ? memData : r_fifo_data[r_rptr];

    assign issueReady = (r_pend[issueReg] != {PCW{1'b1}});
    assign w_inc      = issueValid && issueReady && (issueReg != 5'd0);

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_inc)
            w_inc_vec[issueReg] = 1'b1;
        if (w_wr_fire)
            w_dec_vec[w_wr_reg] = 1'b1;
    end

    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wptr]  <= aluReg;
            r_fifo_data[r_wptr] <= aluData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeEnable <= 1'b0;
            writeReg    <= '0;
            writeData   <= '0;
        end else begin
            writeEnable <= w_wr_fire;
            if (w_wr_fire) begin
                writeReg  <= w_wr_reg;
                writeData <= w_wr_data;
            end
        end
    end

    // A retire at a zero count is a protocol error; the counter saturates at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                r_pend[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i])
                    r_pend[i] <= r_pend[i] + 1'b1;
                else if (w_dec_vec[i] && !w_inc_vec[i] && (r_pend[i] != '0))
                    r_pend[i] <= r_pend[i] - 1'b1;
            end
        end
    end

    // The counter drops on the same edge that raises writeEnable, so busy is already clear
    // when a bypassed write retires the last pending count.
    assign busy1 = (queryReg1 != 5'd0) && (r_pend[queryReg1] != '0);
    assign busy2 = (queryReg2 != 5'd0) && (r_pend[queryReg2] != '0);

`ifdef WB_BYPASS_EN
    assign bypassValid1 = writeEnable && (writeReg == queryReg1) && (queryReg1 != 5'd0);
    assign bypassValid2 = writeEnable && (writeReg == queryReg2) && (queryReg2 != 5'd0);
    assign bypassData1  = writeData;
    assign bypassData2  = writeData;
`else
    assign bypassValid1 = 1'b0;
    assign bypassValid2 = 1'b0;
    assign bypassData1  = '0;
    assign bypassData2  = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed, table-driven bench for writeback_arbiter, plus hand-written bypass and mid-stream reset sequences.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid, memValid, issueValid;
    logic [4:0]  aluReg, memReg, issueReg, queryReg1, queryReg2;
    logic [31:0] aluData, memData;
    logic        aluReady, issueReady, busy1, busy2;
    logic        bypassValid1, bypassValid2;
    logic [31:0] bypassData1, bypassData2;
    logic        writeEnable;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(4), .PCW(3)) dut (
        .clk(clk), .reset(reset),
        .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memReg(memReg), .memData(memData),
        .issueValid(issueValid), .issueReg(issueReg), .issueReady(issueReady),
        .queryReg1(queryReg1), .queryReg2(queryReg2), .busy1(busy1), .busy2(busy2),
        .bypassValid1(bypassValid1), .bypassValid2(bypassValid2),
        .bypassData1(bypassData1), .bypassData2(bypassData2),
        .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        e_ardy;
        logic        e_irdy;
        logic        e_b1;
        logic        e_b2;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
    } vec_t;

    vec_t  vecs[$];
    string tags[$];

    function automatic vec_t mk(int av, int ar, int ad, int mv, int mr, int md, int iv, int ir,
                                int q1, int q2, int ardy, int irdy, int b1, int b2,
                                int we, int wr, int wd);
        vec_t v;
        v.av = 1'(av);   v.ar = 5'(ar);   v.ad = 32'(ad);
        v.mv = 1'(mv);   v.mr = 5'(mr);   v.md = 32'(md);
        v.iv = 1'(iv);   v.ir = 5'(ir);
        v.q1 = 5'(q1);   v.q2 = 5'(q2);
        v.e_ardy = 1'(ardy); v.e_irdy = 1'(irdy);
        v.e_b1 = 1'(b1);     v.e_b2 = 1'(b2);
        v.e_we = 1'(we);     v.e_wr = 5'(wr); v.e_wd = 32'(wd);
        return v;
    endfunction

    function automatic void add(string tag, vec_t v);
        tags.push_back(tag);
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle_inputs();
        aluValid = 1'b0; aluReg = '0; aluData = '0;
        memValid = 1'b0; memReg = '0; memData = '0;
        issueValid = 1'b0; issueReg = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  last_wr;
        logic [31:0] last_wd;
        vec_t v;

        idle_inputs();
        queryReg1 = '0; queryReg2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset writeEnable", 32'(writeEnable), 32'd0);
        check("reset writeReg",    32'(writeReg),    32'd0);
        check("reset writeData",   writeData,        32'd0);
        check("reset aluReady",    32'(aluReady),    32'd1);
        check("reset issueReady",  32'(issueReady),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        last_wr = '0;
        last_wd = '0;

        // ALU result into an idle block
        add("alu_lat", mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,0,0));
        add("alu_lat", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 1,5,32'hDEADBEEF));
        add("alu_lat", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,0,0));
        // Loads win the port while ALU results queue up
        add("load_pri", mk(1,9,32'hAA, 1,7,32'h11, 0,0, 0,0, 1,1,0,0, 1,7,32'h11));
        add("load_pri", mk(1,9,32'hAB, 1,7,32'h22, 0,0, 0,0, 1,1,0,0, 1,7,32'h22));
        add("load_pri", mk(1,9,32'hAC, 1,7,32'h33, 0,0, 0,0, 1,1,0,0, 1,7,32'h33));
        add("load_pri", mk(1,9,32'hAD, 0,0,0,      0,0, 0,0, 1,1,0,0, 1,9,32'hAA));
        add("load_pri", mk(1,9,32'hAE, 1,7,32'h44, 0,0, 0,0, 1,1,0,0, 1,7,32'h44));
        add("load_pri", mk(1,9,32'hAF, 0,0,0,      0,0, 0,0, 0,1,0,0, 1,9,32'hAB));
        add("load_pri", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 1,9,32'hAC));
        add("load_pri", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 1,9,32'hAD));
        add("load_pri", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 1,9,32'hAE));
        add("load_pri", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,0,0));
        // Register 0 traffic never reaches the port
        add("reg0", mk(1,0,32'h55, 1,0,32'h66, 1,0, 0,0, 1,1,0,0, 0,0,0));
        add("reg0", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,0,0));
        add("reg0", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,0,0));
        // Scoreboard on reg 3, including inc+dec in one cycle and a retire at zero
        add("sb_r3", mk(0,0,0, 0,0,0,        1,3, 3,0, 1,1,0,0, 0,0,0));
        add("sb_r3", mk(0,0,0, 0,0,0,        1,3, 3,0, 1,1,1,0, 0,0,0));
        add("sb_r3", mk(0,0,0, 1,3,32'h300, 0,0, 3,0, 1,1,1,0, 1,3,32'h300));
        add("sb_r3", mk(0,0,0, 1,3,32'h301, 1,3, 3,0, 1,1,1,0, 1,3,32'h301));
        add("sb_r3", mk(0,0,0, 1,3,32'h302, 0,0, 3,0, 1,1,1,0, 1,3,32'h302));
        add("sb_r3", mk(0,0,0, 0,0,0,        0,0, 3,0, 1,1,0,0, 0,0,0));
        add("sb_r3", mk(0,0,0, 1,3,32'h303, 0,0, 3,0, 1,1,0,0, 1,3,32'h303));
        add("sb_r3", mk(0,0,0, 0,0,0,        0,0, 3,0, 1,1,0,0, 0,0,0));
        // Saturate the reg 4 counter
        for (int i = 0; i < 8; i++)
            add("sb_r4", mk(0,0,0, 0,0,0, 1,4, 0,4, 1,(i < 7),0,(i > 0), 0,0,0));
        add("sb_r4", mk(0,0,0, 0,0,0, 1,4, 0,4, 1,0,0,1, 0,0,0));

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(negedge clk);
            aluValid = v.av; aluReg = v.ar; aluData = v.ad;
            memValid = v.mv; memReg = v.mr; memData = v.md;
            issueValid = v.iv; issueReg = v.ir;
            queryReg1 = v.q1; queryReg2 = v.q2;
            #1;
            check($sformatf("%s[%0d] aluReady", tags[k], k),   32'(aluReady),   32'(v.e_ardy));
            check($sformatf("%s[%0d] issueReady", tags[k], k), 32'(issueReady), 32'(v.e_irdy));
            check($sformatf("%s[%0d] busy1", tags[k], k),      32'(busy1),      32'(v.e_b1));
            check($sformatf("%s[%0d] busy2", tags[k], k),      32'(busy2),      32'(v.e_b2));
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] writeEnable", tags[k], k), 32'(writeEnable), 32'(v.e_we));
            if (v.e_we) begin
                last_wr = v.e_wr;
                last_wd = v.e_wd;
            end
            check($sformatf("%s[%0d] writeReg", tags[k], k),  32'(writeReg), 32'(last_wr));
            check($sformatf("%s[%0d] writeData", tags[k], k), writeData,     last_wd);
        end

        // Bypass on a load write to reg 12
        @(negedge clk);
        idle_inputs();
        memValid = 1'b1; memReg = 5'd12; memData = 32'h1234;
        queryReg1 = 5'd0; queryReg2 = 5'd12;
        @(posedge clk);
        #1;
        check("bypass writeEnable", 32'(writeEnable), 32'd1);
        check("bypass writeReg",    32'(writeReg),    32'd12);
`ifdef WB_BYPASS_EN
        check("bypass valid2", 32'(bypassValid2), 32'd1);
        check("bypass data2",  bypassData2,       32'h1234);
`else
        check("bypass valid2", 32'(bypassValid2), 32'd0);
        check("bypass data2",  bypassData2,       32'd0);
`endif
        check("bypass valid1 q0", 32'(bypassValid1), 32'd0);
        check("bypass busy2",     32'(busy2),        32'd0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("bypass valid2 idle", 32'(bypassValid2), 32'd0);

        // Reset mid-stream with three ALU entries queued behind loads
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memValid = 1'b1; memReg = 5'd8;  memData = 32'h80 + 32'(i);
            aluValid = 1'b1; aluReg = 5'd10; aluData = 32'h100 + 32'(i);
            issueValid = (i == 0); issueReg = 5'd10;
            queryReg1 = 5'd10; queryReg2 = 5'd8;
        end
        @(posedge clk);
        #1;
        check("pre_rst writeEnable", 32'(writeEnable), 32'd1);
        check("pre_rst writeReg",    32'(writeReg),    32'd8);
        check("pre_rst busy1",       32'(busy1),       32'd1);
        @(negedge clk);
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst writeEnable", 32'(writeEnable), 32'd0);
        check("mid_rst writeReg",    32'(writeReg),    32'd0);
        check("mid_rst writeData",   writeData,        32'd0);
        check("mid_rst aluReady",    32'(aluReady),    32'd1);
        check("mid_rst busy1",       32'(busy1),       32'd0);
        check("mid_rst busy2",       32'(busy2),       32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst[%0d] writeEnable", i), 32'(writeEnable), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
